// File: rtl/rotary_button_input.sv
// rotary_button_input: synchronises and debounces the board push-buttons and
// the rotary encoder, then emits single-cycle press/rotation pulses and a
// wrapping detent position for the downstream ALU. All outputs are flops.

// One input lane: 2-flop synchroniser followed by a mismatch-count debouncer.
module rbi_lane #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,   // settle phase: debounced level follows the synchroniser
   input  logic raw,
   output logic lvl
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // Two-stage synchroniser for the asynchronous board input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Level changes only after DEBOUNCE_CYCLES consecutive mismatching samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl <= 1'b0;
         cnt <= '0;
      end else if (load || (s2 == lvl)) begin
         lvl <= s2;
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         lvl <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

module rotary_button_input #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int POS_W           = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             BTN_EAST,
   input  logic             BTN_NORTH,
   input  logic             BTN_SOUTH,
   input  logic             BTN_WEST,
   input  logic             ROT_A,
   input  logic             ROT_B,
   input  logic             ROT_CENTER,
   output logic [3:0]       oBtnLevel,
   output logic [3:0]       oBtnPress,
   output logic             oCenterPress,
   output logic             oRotCW,
   output logic             oRotCCW,
   output logic [POS_W-1:0] oPosition,
   output logic             oReady
);
   localparam int NUM_LANES = 7;
   localparam int SW        = $clog2(DEBOUNCE_CYCLES + 2);
   // Lane map: [3:0] buttons E,N,S,W; 4 = ROT_A; 5 = ROT_B; 6 = ROT_CENTER.
   localparam int L_A = 4, L_B = 5, L_C = 6;

   typedef enum logic {SETTLE, RUN} state_t;

   state_t                 state, state_nxt;
   logic [SW-1:0]          settle_cnt;
   logic                   settle_done;
   logic                   settle;
   logic [NUM_LANES-1:0]   raw, lvl, lvl_q;
   logic [3:0]             press_rise;
   logic                   a_rise, c_rise, cw, ccw;

   assign raw = {ROT_CENTER, ROT_B, ROT_A, BTN_WEST, BTN_SOUTH, BTN_NORTH, BTN_EAST};
   assign settle = (state == SETTLE);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      rbi_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
         .clk   (Clock),
         .rst_n (Reset),
         .load  (settle),
         .raw   (raw[i]),
         .lvl   (lvl[i])
      );
   end

   // No reset synchroniser: the settle window absorbs the release, and a
   // direct release gives an exact, deterministic ready latency.
   assign settle_done = (settle_cnt == SW'(DEBOUNCE_CYCLES + 1));

   // State register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= SETTLE;
      else        state <= state_nxt;
   end

   // Next state: SETTLE runs out its window, RUN is left only by reset.
   always_comb begin
      state_nxt = state;
      if (state == SETTLE && settle_done) state_nxt = RUN;
   end

   // Settle window counter, frozen once running.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)      settle_cnt <= '0;
      else if (settle) settle_cnt <= settle_cnt + SW'(1);
   end

   assign press_rise = lvl[3:0] & ~lvl_q[3:0];
   assign a_rise     = lvl[L_A] & ~lvl_q[L_A];
   assign c_rise     = lvl[L_C] & ~lvl_q[L_C];
   // Direction comes from B as it stood the cycle before A's rising edge.
   assign cw         = a_rise & ~lvl_q[L_B];
   assign ccw        = a_rise &  lvl_q[L_B];

   // Edge detection, pulse outputs and the position counter.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         lvl_q        <= '0;
         oBtnPress    <= '0;
         oCenterPress <= 1'b0;
         oRotCW       <= 1'b0;
         oRotCCW      <= 1'b0;
         oPosition    <= '0;
      end else begin
         lvl_q        <= lvl;
         oBtnPress    <= settle ? 4'b0 : press_rise;
         oCenterPress <= !settle && c_rise;
         oRotCW       <= !settle && cw;
         oRotCCW      <= !settle && ccw;
         if (!settle) begin
            if (c_rise)   oPosition <= '0;
            else if (cw)  oPosition <= oPosition + POS_W'(1);
            else if (ccw) oPosition <= oPosition - POS_W'(1);
         end
      end
   end

   assign oBtnLevel = lvl[3:0];
   assign oReady    = (state == RUN);
endmodule

// File: tb/tb_rotary_button_input.sv
// Scoreboard bench for rotary_button_input with DEBOUNCE_CYCLES=4, POS_W=4.
module tb_rotary_button_input;
   localparam int D  = 4;
   localparam int PW = 4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          BTN_EAST, BTN_NORTH, BTN_SOUTH, BTN_WEST;
   logic          ROT_A, ROT_B, ROT_CENTER;
   logic [3:0]    oBtnLevel, oBtnPress;
   logic          oCenterPress, oRotCW, oRotCCW, oReady;
   logic [PW-1:0] oPosition;

   rotary_button_input #(.DEBOUNCE_CYCLES(D), .POS_W(PW)) dut (
      .Clock(Clock), .Reset(Reset),
      .BTN_EAST(BTN_EAST), .BTN_NORTH(BTN_NORTH), .BTN_SOUTH(BTN_SOUTH), .BTN_WEST(BTN_WEST),
      .ROT_A(ROT_A), .ROT_B(ROT_B), .ROT_CENTER(ROT_CENTER),
      .oBtnLevel(oBtnLevel), .oBtnPress(oBtnPress), .oCenterPress(oCenterPress),
      .oRotCW(oRotCW), .oRotCCW(oRotCCW), .oPosition(oPosition), .oReady(oReady)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]    press;
      logic          center;
      logic          cw;
      logic          ccw;
      logic [PW-1:0] pos;
      int            cyc;
   } ev_t;

   ev_t           sb[$];
   ev_t           mon_e;
   logic [PW-1:0] exp_pos;
   int            ccw_seen = 0;
   int            total = 0, bad = 0;

   // Every pulse cycle must match the oldest expected event, including its cycle.
   always @(negedge Clock) begin
      if (Reset === 1'b1 && (oBtnPress != 4'b0 || oCenterPress || oRotCW || oRotCCW)) begin
         if (oRotCCW) ccw_seen++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse got press=%b center=%b cw=%b ccw=%b pos=%h cyc=%0d, required no pulse",
                     oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition, cyc);
         end else begin
            mon_e = sb.pop_front();
            if ({oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition} !==
                {mon_e.press, mon_e.center, mon_e.cw, mon_e.ccw, mon_e.pos} || cyc != mon_e.cyc) begin
               bad++;
               $display("FAIL pulse_event got press=%b center=%b cw=%b ccw=%b pos=%h cyc=%0d, required press=%b center=%b cw=%b ccw=%b pos=%h cyc=%0d",
                        oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition, cyc,
                        mon_e.press, mon_e.center, mon_e.cw, mon_e.ccw, mon_e.pos, mon_e.cyc);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // Expected event for a raw change driven at the current negedge.
   task automatic push_ev(input logic [3:0] p, input logic c, input logic r_cw, input logic r_ccw);
      ev_t e;
      e.press = p; e.center = c; e.cw = r_cw; e.ccw = r_ccw;
      e.pos = exp_pos; e.cyc = cyc + 3 + D;
      sb.push_back(e);
   endtask

   task automatic detent(input bit is_ccw);
      exp_pos = is_ccw ? exp_pos - 4'd1 : exp_pos + 4'd1;
      push_ev(4'b0, 1'b0, !is_ccw, is_ccw);
      ROT_A = 1'b1;
      step(8);
      ROT_A = 1'b0;
      step(8);
   endtask

   task automatic test_reset();
      int c0, rc;
      Reset = 1'b0;
      BTN_EAST = 0; BTN_NORTH = 1; BTN_SOUTH = 0; BTN_WEST = 0;
      ROT_A = 0; ROT_B = 0; ROT_CENTER = 0;
      exp_pos = '0;
      step(3);
      total++;
      if ({oBtnLevel, oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition, oReady} !== 16'h0) begin
         bad++;
         $display("FAIL reset_outputs got %h, required 0",
                  {oBtnLevel, oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition, oReady});
      end
      Reset = 1'b1;
      c0 = cyc; rc = -1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (oReady === 1'b1 && rc < 0) rc = cyc;
      end
      total++;
      if (rc != c0 + D + 2) begin
         bad++;
         $display("FAIL ready_latency got cyc=%0d, required cyc=%0d", rc, c0 + D + 2);
      end
      total++;
      if (oBtnLevel !== 4'b0010) begin
         bad++;
         $display("FAIL held_level got %b, required 0010", oBtnLevel);
      end
      total++;
      if (oPosition !== 4'h0) begin
         bad++;
         $display("FAIL reset_position got %h, required 0", oPosition);
      end
   endtask

   task automatic test_press();
      push_ev(4'b0001, 1'b0, 1'b0, 1'b0);
      BTN_EAST = 1'b1;
      step(10);
      total++;
      if (oBtnLevel !== 4'b0011) begin
         bad++;
         $display("FAIL east_level got %b, required 0011", oBtnLevel);
      end
      BTN_WEST = 1'b1;
      step(3);
      BTN_WEST = 1'b0;
      step(12);
      total++;
      if (oBtnLevel !== 4'b0011) begin
         bad++;
         $display("FAIL west_glitch got %b, required 0011", oBtnLevel);
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL press_pending got %0d, required 0", sb.size());
      end
   endtask

   task automatic test_rotation();
      total++;
      if (oPosition !== 4'h0) begin
         bad++;
         $display("FAIL rot_start got %h, required 0", oPosition);
      end
      for (int i = 0; i < 3; i++) detent(1'b0);
      total++;
      if (oPosition !== 4'h3) begin
         bad++;
         $display("FAIL cw3_position got %h, required 3", oPosition);
      end
      ROT_B = 1'b1;
      step(8);
      for (int i = 0; i < 5; i++) detent(1'b1);
      ROT_B = 1'b0;
      step(8);
      total++;
      if (oPosition !== 4'hE) begin
         bad++;
         $display("FAIL ccw5_position got %h, required e", oPosition);
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL rot_pending got %0d, required 0", sb.size());
      end
   endtask

   task automatic test_wrap();
      exp_pos = '0;
      push_ev(4'b0, 1'b1, 1'b0, 1'b0);
      ROT_CENTER = 1'b1;
      step(8);
      ROT_CENTER = 1'b0;
      step(8);
      ccw_seen = 0;
      for (int i = 0; i < 17; i++) detent(1'b0);
      total++;
      if (oPosition !== 4'h1) begin
         bad++;
         $display("FAIL wrap_position got %h, required 1", oPosition);
      end
      total++;
      if (ccw_seen != 0) begin
         bad++;
         $display("FAIL wrap_ccw got %0d pulses, required 0", ccw_seen);
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL wrap_pending got %0d, required 0", sb.size());
      end
   endtask

   task automatic test_coincide();
      exp_pos = '0;
      push_ev(4'b0, 1'b1, 1'b1, 1'b0);
      ROT_CENTER = 1'b1;
      ROT_A = 1'b1;
      step(8);
      total++;
      if (oPosition !== 4'h0) begin
         bad++;
         $display("FAIL center_priority got %h, required 0", oPosition);
      end
      ROT_CENTER = 1'b0;
      ROT_A = 1'b0;
      step(8);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL coincide_pending got %0d, required 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int c0, rc;
      BTN_SOUTH = 1'b1;
      step(4);
      Reset = 1'b0;
      #1;
      total++;
      if ({oBtnLevel, oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition, oReady} !== 16'h0) begin
         bad++;
         $display("FAIL async_reset got %h, required 0",
                  {oBtnLevel, oBtnPress, oCenterPress, oRotCW, oRotCCW, oPosition, oReady});
      end
      step(2);
      Reset = 1'b1;
      exp_pos = '0;
      c0 = cyc; rc = -1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (oReady === 1'b1 && rc < 0) rc = cyc;
      end
      total++;
      if (rc != c0 + D + 2) begin
         bad++;
         $display("FAIL ready_latency2 got cyc=%0d, required cyc=%0d", rc, c0 + D + 2);
      end
      total++;
      if (oBtnLevel !== 4'b0111) begin
         bad++;
         $display("FAIL held_level2 got %b, required 0111", oBtnLevel);
      end
      step(10);
      total++;
      if (oBtnLevel !== 4'b0111 || oPosition !== 4'h0 || sb.size() != 0) begin
         bad++;
         $display("FAIL after_reset got level=%b pos=%h pending=%0d, required level=0111 pos=0 pending=0",
                  oBtnLevel, oPosition, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_rotation();
      test_wrap();
      test_coincide();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rotary_button_input.md
# rotary_button_input

Input-conditioning stage that sits directly upstream of `MiniAlu`. It takes the raw board-level user controls, synchronises and debounces them, and hands `MiniAlu` clean single-cycle events:
- controls: four push-buttons, the rotary-encoder quadrature pair and its push switch;
- events produced: press pulses, rotation pulses and a wrapping position count.

All outputs are registered. `MiniAlu` consumes them on the same `Clock`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required before a debounced level changes; legal range 2..2^20.
- `POS_W`, default 8: width of the rotary position counter.

Ports:
- `Clock` in 1: system clock; all logic is on its rising edge.
- `Reset` in 1: asynchronous, active-low reset (asserted at 0).
- `BTN_EAST`, `BTN_NORTH`, `BTN_SOUTH`, `BTN_WEST` in 1 each: raw push-buttons, active-high, asynchronous to `Clock`.
- `ROT_A`, `ROT_B` in 1 each: raw quadrature pair from the rotary encoder.
- `ROT_CENTER` in 1: raw encoder push switch, active-high.
- `oBtnLevel` out 4: debounced button levels, ordered {WEST, SOUTH, NORTH, EAST} (bit 0 = EAST).
- `oBtnPress` out 4: one-cycle pulse on each debounced 0->1 button transition; same bit order.
- `oCenterPress` out 1: one-cycle pulse on debounced `ROT_CENTER` 0->1.
- `oRotCW` out 1: one-cycle pulse per clockwise detent.
- `oRotCCW` out 1: one-cycle pulse per counter-clockwise detent.
- `oPosition` out POS_W: wrapping detent count.
- `oReady` out 1: high once the settle phase has ended.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each of the 7 raw inputs.
- **Debouncer, one per input:**
  - Holds a debounced level and a mismatch counter.
  - In a cycle where the synchronised value equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while a mismatch is present, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the level.
- **Control FSM, 2 states:**
  - SETTLE (reset state): a settle counter runs for `DEBOUNCE_CYCLES`+2 cycles. The debounced levels load the synchronised values directly every cycle. All pulse outputs are forced to 0 and `oReady`=0. At terminal count the FSM moves to RUN.
  - RUN: normal debouncing and edge detection. `oReady`=1. RUN is only left through `Reset`.
- **Edge detection:** compares each debounced level with its registered value from the previous cycle.
- **Quadrature decode:**
  - On a debounced `ROT_A` 0->1 transition, the direction comes from the debounced `ROT_B` value registered in the previous cycle: 0 gives `oRotCW`, 1 gives `oRotCCW`.
  - Debounced `ROT_A` 1->0 transitions and any `ROT_B` transition generate nothing.
  - `oRotCW` and `oRotCCW` are never high in the same cycle.
- **Position counter:**
  - CW adds 1 and CCW subtracts 1, modulo 2^POS_W: 2^POS_W-1 +1 gives 0, and 0 -1 gives 2^POS_W-1.
  - `oCenterPress` clears the position to 0 and has priority over a rotation event in the same cycle.
  - The position update is visible in the same cycle as its pulse.
- **Simultaneous events:** independent inputs may pulse in the same cycle; every pulse is reported and none is dropped or serialised.

## Timing
- **Reset values:** during `Reset`=0 every output is 0. FSM = SETTLE, all counters 0, synchronisers and debounced levels 0.
- **Reset release:**
  - `Reset` is released asynchronously, so synchronise its deassertion internally if required.
  - `oReady` rises exactly `DEBOUNCE_CYCLES`+2 rising edges after the first edge with `Reset`=1.
  - An input already high at release appears on `oBtnLevel` but produces no press or rotation pulse.
- **Latency in RUN:** for a raw change sampled at edge n:
  - the synchroniser output changes at n+1;
  - the debounced level changes at n+1+`DEBOUNCE_CYCLES`;
  - pulses and `oPosition` update at edge n+2+`DEBOUNCE_CYCLES` and stay high for exactly one cycle.
- **Reset mid-operation:** asserting `Reset` at any point clears all state immediately, without waiting for a clock edge. A partially counted debounce is discarded and the block re-enters SETTLE.
- **Throughput:** at most one event per input every `DEBOUNCE_CYCLES` cycles; no backpressure, no handshake.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `POS_W`=4 and a 10 ns clock.
1. Reset with `BTN_NORTH`=1 held -> all outputs 0 during reset; `oReady` rises 6 edges after release; `oBtnLevel`=4'b0010 and `oBtnPress` is never asserted.
2. In RUN, raise `BTN_EAST` and hold -> `oBtnPress`=4'b0001 for exactly one cycle, 6 edges after the change; `oBtnLevel[0]`=1. A 3-cycle pulse on `BTN_WEST` -> no output change.
3. Run 3 CW detents (A rises while B=0) starting from `oPosition`=0 -> three `oRotCW` pulses and `oPosition`=3. Then 5 CCW detents -> `oPosition`=14 (4'hE), wrapping through 0.
4. Run 17 CW detents from 0 -> `oPosition`=1, confirming the 15->0 wrap; `oRotCCW` stays 0 throughout.
5. Make an `oCenterPress` and an `oRotCW` pulse coincide -> `oPosition`=0 and both pulses are visible that cycle.
6. Assert `Reset` with a debounce counter at 2 -> outputs go to 0 before the next edge; after release the block behaves as in scenario 1.
